parking_lot_controller: RTL and testbench
=========================================

// Module: parking_lot_controller
// PURPOSE
//  Multi-space parking controller. Separate entry and exit lanes, each with its own gate FSM.
//  Entry requires a password. Tracks occupancy up to CAPACITY and refuses entry when the lot is full.
//  Sits between lane sensors/keypad and the gate actuators plus a 7-bit status display.
// PARAMETERS
//  CAPACITY          8      number of parking spaces (>=1)
//  CNT_W             4      occupancy width; must satisfy 2**CNT_W > CAPACITY
//  PW_W              4      password width
//  PASSWORD          13     accepted password (PW_W bits)
//  TIMEOUT_CYCLES    10000  cycles allowed in PASSWORD_ENTRY
//  GATE_HOLD_CYCLES  100    max cycles a gate stays open without a car passing
//  MAX_TRIES         3      wrong submissions allowed before the request is aborted
//  LOCKOUT_CYCLES    1000   lockout length (only with PARKING_LOCKOUT_EN)
// PORTS
//  clock            in   1     system clock, rising edge
//  reset            in   1     synchronous, active-high
//  entrance_sensor  in   1     car present at entry lane
//  exit_sensor      in   1     car present at exit lane
//  password_input   in   PW_W  keypad value
//  password_valid   in   1     1-cycle strobe: submit password_input
//  entrance_gate    out  1     1 = entry gate open
//  exit_gate        out  1     1 = exit gate open
//  occupancy        out  CNT_W cars currently inside
//  lot_full         out  1     occupancy == CAPACITY
//  lot_empty        out  1     occupancy == 0
//  denied           out  1     1-cycle pulse on a wrong submission
//  locked           out  1     entry locked out (always 0 without PARKING_LOCKOUT_EN)
//  display          out  7     status display
// BEHAVIOUR
//  - Reset:
//    - Both FSMs go idle; all counters clear. occupancy=0, lot_empty=1.
//    - All other outputs are 0; display=0.
//  - Output timing:
//    - All outputs are combinational decodes of registered state.
//    - A transition on edge N is visible after edge N.
//  - Entry FSM: E_IDLE, PASSWORD_ENTRY, ENTRY_OPEN, LOCKOUT (macro only).
//    - E_IDLE: entrance_sensor && !lot_full -> PASSWORD_ENTRY. Clear timer and try count.
//      While lot_full, the sensor is ignored.
//    - PASSWORD_ENTRY: timer increments every cycle.
//      - password_valid && match -> ENTRY_OPEN.
//      - password_valid && mismatch -> denied pulse, tries+1. If tries reaches MAX_TRIES -> E_IDLE.
//      - No valid by timer == TIMEOUT_CYCLES-1 -> E_IDLE.
//      - password_valid on the timeout cycle: the submission wins.
//    - ENTRY_OPEN: entrance_gate=1; hold counter runs.
//      - Falling edge of entrance_sensor (car passed) -> occupancy+1, then E_IDLE.
//      - Hold counter reaches GATE_HOLD_CYCLES-1 with no passage -> E_IDLE, occupancy unchanged.
//  - Exit FSM: X_IDLE, EXIT_OPEN. Independent of the entry FSM.
//    - X_IDLE: exit_sensor && !lot_empty -> EXIT_OPEN. Sensor ignored while empty.
//    - EXIT_OPEN: exit_gate=1.
//      - Falling edge of exit_sensor -> occupancy-1, then X_IDLE.
//      - Hold timeout -> X_IDLE, occupancy unchanged.
//  - Occupancy arithmetic:
//    - Increment and decrement in the same cycle -> occupancy unchanged.
//    - Saturates at CAPACITY and at 0; never wraps.
//  - Display priority:
//    1. locked -> 7'h7F.
//    2. PASSWORD_ENTRY -> password_input, zero-extended or truncated to 7 bits.
//    3. Otherwise -> occupancy, zero-extended to 7 bits.
//  - reset asserted in any state overrides everything on that edge; any open gate closes.
// CONFIGURATION
//  - PARKING_LOCKOUT_EN defined:
//    - Reaching MAX_TRIES -> LOCKOUT instead of E_IDLE.
//    - In LOCKOUT: locked=1 and entrance_sensor is ignored.
//    - After LOCKOUT_CYCLES cycles -> E_IDLE.
//  - PARKING_LOCKOUT_EN undefined: no LOCKOUT state; locked tied to 0.
// TESTING (TIMEOUT_CYCLES=20, GATE_HOLD_CYCLES=10, CAPACITY=2, LOCKOUT_CYCLES=8)
//  - Entry: sensor=1, submit 13 -> entrance_gate=1 next cycle. Drop sensor -> occupancy=1, gate=0.
//  - 3 wrong submits (5,6,7) -> 3 denied pulses, then E_IDLE, gate never opens.
//    With macro: locked=1 for 8 cycles, display=7'h7F.
//  - Sensor=1 and no submit for 20 cycles -> back to E_IDLE. Submit on cycle 20 -> gate opens.
//  - Fill to 2: lot_full=1; new entrance_sensor ignored. Exit a car -> occupancy=1, lot_full=0.
//  - Entry and exit passages complete on the same edge at occupancy=1 -> occupancy stays 1.
//  - Gate open, no passage for 10 cycles -> gate closes, occupancy unchanged.
//    reset mid-ENTRY_OPEN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/parking_lot_controller.sv
// Two-lane parking controller: password-gated entry FSM, independent exit FSM, saturating occupancy.
// Optional entry lockout after repeated wrong passwords is enabled by defining PARKING_LOCKOUT_EN.
module parking_lot_controller #(
    parameter int CAPACITY         = 8,
    parameter int CNT_W            = 4,
    parameter int PW_W             = 4,
    parameter int PASSWORD         = 13,
    parameter int TIMEOUT_CYCLES   = 10000,
    parameter int GATE_HOLD_CYCLES = 100,
    parameter int MAX_TRIES        = 3,
    parameter int LOCKOUT_CYCLES   = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             entrance_sensor,
    input  logic             exit_sensor,
    input  logic [PW_W-1:0]  password_input,
    input  logic             password_valid,
    output logic             entrance_gate,
    output logic             exit_gate,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             denied,
    output logic             locked,
    output logic [6:0]       display
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(GATE_HOLD_CYCLES + 1);
    localparam int RW = $clog2(MAX_TRIES + 1);

    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LAST    = HW'(GATE_HOLD_CYCLES - 1);
    localparam logic [RW-1:0]    TRIES_LAST   = RW'(MAX_TRIES - 1);
    localparam logic [CNT_W-1:0] CAP_VAL      = CNT_W'(CAPACITY);
    localparam logic [PW_W-1:0]  PW_VAL       = PW_W'(PASSWORD);

    generate
        if (CAPACITY < 1 || (2 ** CNT_W) <= CAPACITY || TIMEOUT_CYCLES < 1 || GATE_HOLD_CYCLES < 1
            || MAX_TRIES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
            $error("parking_lot_controller: invalid parameter set");
        end
    endgenerate

`ifdef PARKING_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    typedef enum logic [1:0] {E_IDLE = 2'd0, PASSWORD_ENTRY = 2'd1, ENTRY_OPEN = 2'd2, LOCKOUT = 2'd3} entry_state_t;
    logic [LW-1:0] r_lock_cnt;
`else
    typedef enum logic [1:0] {E_IDLE = 2'd0, PASSWORD_ENTRY = 2'd1, ENTRY_OPEN = 2'd2} entry_state_t;
`endif
    typedef enum logic {X_IDLE = 1'b0, EXIT_OPEN = 1'b1} exit_state_t;

    entry_state_t     r_e_state;
    exit_state_t      r_x_state;
    logic [TW-1:0]    r_timer;
    logic [RW-1:0]    r_tries;
    logic [HW-1:0]    r_hold_e;
    logic [HW-1:0]    r_hold_x;
    logic [CNT_W-1:0] r_occ;
    logic             r_denied;
    logic             r_ent_prev;
    logic             r_exit_prev;

    logic             w_full;
    logic             w_empty;
    logic             w_match;
    logic             w_entry_pass;
    logic             w_exit_pass;
    logic [6:0]       w_pw_disp;
    logic [6:0]       w_occ_disp;
    logic [6:0]       w_display;

    assign w_full       = (r_occ == CAP_VAL);
    assign w_empty      = (r_occ == {CNT_W{1'b0}});
    assign w_match      = (password_input == PW_VAL);
    // A passage is the sensor falling while its gate is open.
    assign w_entry_pass = (r_e_state == ENTRY_OPEN) && r_ent_prev && !entrance_sensor;
    assign w_exit_pass  = (r_x_state == EXIT_OPEN) && r_exit_prev && !exit_sensor;

    // Sensor history for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ent_prev  <= 1'b0;
            r_exit_prev <= 1'b0;
        end else begin
            r_ent_prev  <= entrance_sensor;
            r_exit_prev <= exit_sensor;
        end
    end

    // Entry lane FSM with password timer, retry count and gate hold timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_e_state  <= E_IDLE;
            r_timer    <= '0;
            r_tries    <= '0;
            r_hold_e   <= '0;
            r_denied   <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_denied <= 1'b0;
            case (r_e_state)
                E_IDLE: begin
                    r_timer  <= '0;
                    r_tries  <= '0;
                    r_hold_e <= '0;
                    if (entrance_sensor && !w_full) begin
                        r_e_state <= PASSWORD_ENTRY;
                    end
                end
                PASSWORD_ENTRY: begin
                    r_timer <= r_timer + TW'(1);
                    if (password_valid) begin
                        if (w_match) begin
                            r_e_state <= ENTRY_OPEN;
                            r_hold_e  <= '0;
                        end else begin
                            r_denied <= 1'b1;
                            r_tries  <= r_tries + RW'(1);
                            if (r_tries == TRIES_LAST) begin
`ifdef PARKING_LOCKOUT_EN
                                r_e_state  <= LOCKOUT;
                                r_lock_cnt <= '0;
`else
                                r_e_state <= E_IDLE;
`endif
                            end
                        end
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_e_state <= E_IDLE;
                    end
                end
                ENTRY_OPEN: begin
                    r_hold_e <= r_hold_e + HW'(1);
                    if (w_entry_pass || (r_hold_e == HOLD_LAST)) begin
                        r_e_state <= E_IDLE;
                    end
                end
`ifdef PARKING_LOCKOUT_EN
                LOCKOUT: begin
                    r_lock_cnt <= r_lock_cnt + LW'(1);
                    if (r_lock_cnt == LOCK_LAST) begin
                        r_e_state <= E_IDLE;
                    end
                end
`endif
                default: begin
                    r_e_state <= E_IDLE;
                end
            endcase
        end
    end

    // Exit lane FSM with gate hold timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x_state <= X_IDLE;
            r_hold_x  <= '0;
        end else begin
            case (r_x_state)
                X_IDLE: begin
                    r_hold_x <= '0;
                    if (exit_sensor && !w_empty) begin
                        r_x_state <= EXIT_OPEN;
                    end
                end
                EXIT_OPEN: begin
                    r_hold_x <= r_hold_x + HW'(1);
                    if (w_exit_pass || (r_hold_x == HOLD_LAST)) begin
                        r_x_state <= X_IDLE;
                    end
                end
                default: begin
                    r_x_state <= X_IDLE;
                end
            endcase
        end
    end

    // Occupancy: simultaneous entry and exit cancel; saturates at both ends.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ <= '0;
        end else if (w_entry_pass && !w_exit_pass && !w_full) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (w_exit_pass && !w_entry_pass && !w_empty) begin
            r_occ <= r_occ - CNT_W'(1);
        end else begin
            r_occ <= r_occ;
        end
    end

    generate
        if (PW_W >= 7) begin : g_pw_trunc
            assign w_pw_disp = password_input[6:0];
        end else begin : g_pw_ext
            assign w_pw_disp = {{(7 - PW_W){1'b0}}, password_input};
        end
        if (CNT_W >= 7) begin : g_occ_trunc
            assign w_occ_disp = r_occ[6:0];
        end else begin : g_occ_ext
            assign w_occ_disp = {{(7 - CNT_W){1'b0}}, r_occ};
        end
    endgenerate

`ifdef PARKING_LOCKOUT_EN
    assign locked = (r_e_state == LOCKOUT);
`else
    assign locked = 1'b0;
`endif

    // Display source selection: lockout banner, then keypad echo, then occupancy.
    always_comb begin
        w_display = 7'd0;
        if (locked) begin
            w_display = 7'h7F;
        end else if (r_e_state == PASSWORD_ENTRY) begin
            w_display = w_pw_disp;
        end else begin
            w_display = w_occ_disp;
        end
    end

    assign entrance_gate = (r_e_state == ENTRY_OPEN);
    assign exit_gate     = (r_x_state == EXIT_OPEN);
    assign occupancy     = r_occ;
    assign lot_full      = w_full;
    assign lot_empty     = w_empty;
    assign denied        = r_denied;
    assign display       = w_display;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Scoreboard bench for parking_lot_controller (CAPACITY=2, timeout 20, hold 10, lockout 8).
// Lockout expectations follow PARKING_LOCKOUT_EN when it is defined for the build.
module tb_parking_lot_controller;

`ifdef PARKING_LOCKOUT_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif
    localparam logic [6:0] LK_DISP = LK ? 7'h7F : 7'd1;

    typedef struct packed {
        logic       es;
        logic       xs;
        logic [3:0] pw;
        logic       pv;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic       eg;
        logic       xg;
        logic [3:0] occ;
        logic       full;
        logic       empty;
        logic       den;
        logic       lck;
        logic [6:0] disp;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       entrance_sensor;
    logic       exit_sensor;
    logic [3:0] password_input;
    logic       password_valid;
    logic       entrance_gate;
    logic       exit_gate;
    logic [3:0] occupancy;
    logic       lot_full;
    logic       lot_empty;
    logic       denied;
    logic       locked;
    logic [6:0] display;
    exp_t       w_obs;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    parking_lot_controller #(
        .CAPACITY(2), .CNT_W(4), .PW_W(4), .PASSWORD(13), .TIMEOUT_CYCLES(20),
        .GATE_HOLD_CYCLES(10), .MAX_TRIES(3), .LOCKOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .entrance_sensor(entrance_sensor), .exit_sensor(exit_sensor),
        .password_input(password_input), .password_valid(password_valid),
        .entrance_gate(entrance_gate), .exit_gate(exit_gate), .occupancy(occupancy),
        .lot_full(lot_full), .lot_empty(lot_empty), .denied(denied), .locked(locked), .display(display)
    );

    assign w_obs = {entrance_gate, exit_gate, occupancy, lot_full, lot_empty, denied, locked, display};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic stim_t st(input logic es, input logic xs, input logic [3:0] pw,
                                 input logic pv, input logic rst);
        st = {es, xs, pw, pv, rst};
    endfunction

    // Expected outputs; full/empty follow from the occupancy for CAPACITY=2.
    function automatic exp_t ex(input logic eg, input logic xg, input logic [3:0] occ,
                                input logic den, input logic lck, input logic [6:0] disp);
        ex = {eg, xg, occ, (occ == 4'd2), (occ == 4'd0), den, lck, disp};
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b1, 4'd5, 1'b1, 1'b1), ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0));
        add(st(1'b0, 1'b1, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL reset v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_entry();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b0, 4'd9, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 7'd9));
        add(st(1'b1, 1'b0, 4'd13, 1'b1, 1'b0), ex(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL entry v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_denied();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd0));
        add(st(1'b1, 1'b0, 4'd5, 1'b1, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 7'd5));
        add(st(1'b1, 1'b0, 4'd6, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd6));
        add(st(1'b1, 1'b0, 4'd6, 1'b1, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 7'd6));
        add(st(1'b1, 1'b0, 4'd7, 1'b1, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b1, LK, LK_DISP));
        // With lockout the sensor stays high to show it is ignored while locked.
        for (int i = 0; i < 7; i++) begin
            add(st(LK, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, LK, LK_DISP));
        end
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL denied v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b0, 4'd3, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd3));
        for (int i = 0; i < 19; i++) begin
            add(st(1'b0, 1'b0, 4'd3, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd3));
        end
        add(st(1'b0, 1'b0, 4'd3, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        // Second request: the correct password arrives on the final allowed cycle.
        add(st(1'b1, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd0));
        for (int i = 0; i < 19; i++) begin
            add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd0));
        end
        add(st(1'b0, 1'b0, 4'd13, 1'b1, 1'b0), ex(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL timeout v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_gate_hold();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 9; i++) begin
            add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        end
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL gate_hold v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_fill();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd0));
        add(st(1'b1, 1'b0, 4'd13, 1'b1, 1'b0), ex(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 7'd2));
        add(st(1'b1, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 7'd2));
        add(st(1'b1, 1'b0, 4'd13, 1'b1, 1'b0), ex(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 7'd2));
        add(st(1'b0, 1'b1, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 7'd2));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL fill v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b1, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 7'd0));
        add(st(1'b1, 1'b1, 4'd13, 1'b1, 1'b0), ex(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL simultaneous v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        exp_t  e;
        add(st(1'b1, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 7'd0));
        add(st(1'b1, 1'b0, 4'd13, 1'b1, 1'b0), ex(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 7'd1));
        add(st(1'b1, 1'b0, 4'd0, 1'b0, 1'b1), ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0));
        add(st(1'b0, 1'b0, 4'd0, 1'b0, 1'b0), ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {entrance_sensor, exit_sensor, password_input, password_valid, reset} = s;
            @(posedge clock); #1;
            e = exp_q.pop_front();
            vectors++;
            if (w_obs !== e) begin
                miscompares++;
                $display("FAIL reset_mid v%0d: got %h want %h", vectors, w_obs, e);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        entrance_sensor = 1'b0;
        exit_sensor     = 1'b0;
        password_input  = 4'd0;
        password_valid  = 1'b0;
        test_reset();
        test_entry();
        test_denied();
        test_timeout();
        test_gate_hold();
        test_fill();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
